// File: rtl/acc_drain.sv
`default_nettype none
// ============================================================================
// Module   : acc_drain
// Brief    : Drains one N_KERNEL-lane accumulator word as rounded, shifted,
//            saturated B_PIXEL-bit pixels on a valid/ready stream, lane 0 first.
//            Optional saturation counter: define ACC_DRAIN_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module acc_drain #(
    parameter int N_KERNEL = 3,
    parameter int B_PIXEL  = 16,
    parameter int SHIFT_W  = 5
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [2*B_PIXEL*N_KERNEL-1:0]   acc_i,
    input  logic                            acc_valid_i,
    output logic                            acc_ready_o,
    input  logic [SHIFT_W-1:0]              shift_i,
    output logic                            clk_en_o,
    output logic [B_PIXEL-1:0]              m_tdata_o,
    output logic                            m_tvalid_o,
    output logic                            m_tlast_o,
    input  logic                            m_tready_i,
    output logic [15:0]                     sat_cnt_o
);

    localparam int c_ACC_W = 2 * B_PIXEL;
    localparam int c_IDX_W = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1;
    localparam logic [c_IDX_W-1:0]       c_LAST_IDX = c_IDX_W'(N_KERNEL - 1);
    localparam logic signed [c_ACC_W:0]  c_ONE      = (c_ACC_W+1)'(1);
    localparam logic signed [c_ACC_W:0]  c_PIX_MAX  =
        {{(c_ACC_W-B_PIXEL+2){1'b0}}, {(B_PIXEL-1){1'b1}}};
    localparam logic signed [c_ACC_W:0]  c_PIX_MIN  =
        {{(c_ACC_W-B_PIXEL+2){1'b1}}, {(B_PIXEL-1){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_IDX_W-1:0]            r_idx;
    logic [c_IDX_W-1:0]            w_idx_nxt;
    logic [2*B_PIXEL*N_KERNEL-1:0] r_acc;
    logic [SHIFT_W-1:0]            r_shift;
    logic                          w_last;
    logic                          w_capture;

    logic [c_ACC_W-1:0]            w_lane;
    logic signed [c_ACC_W:0]       w_x;
    logic signed [c_ACC_W:0]       w_rnd;
    logic signed [c_ACC_W:0]       w_sum;
    logic signed [c_ACC_W:0]       w_y;
    logic                          w_sat_hi;
    logic                          w_sat_lo;
    logic [B_PIXEL-1:0]            w_pix;

    assign w_last    = (r_idx == c_LAST_IDX);
    assign w_capture = acc_valid_i & acc_ready_o;
    assign clk_en_o  = acc_ready_o;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        acc_ready_o = 1'b0;
        m_tvalid_o  = 1'b0;
        m_tlast_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                acc_ready_o = 1'b1;
                if (acc_valid_i) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = '0;
                end
            end
            S_SEND: begin
                m_tvalid_o  = 1'b1;
                m_tlast_o   = w_last;
                // Accepting on the last handshake keeps consecutive words bubble-free
                acc_ready_o = w_last & m_tready_i;
                if (m_tready_i) begin
                    if (!w_last) begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end else begin
                        w_idx_nxt = '0;
                        if (!acc_valid_i) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_capture) begin
                r_acc   <= acc_i;
                r_shift <= shift_i;
            end
        end
    end

    assign w_lane = r_acc[r_idx*c_ACC_W +: c_ACC_W];
    assign w_x    = {w_lane[c_ACC_W-1], w_lane};

    // One guard bit absorbs the rounding carry before the arithmetic shift
    always_comb begin
        w_rnd = '0;
        w_sum = w_x;
        w_y   = w_x;
        if (32'(r_shift) >= 32'(c_ACC_W)) begin
            w_y = {(c_ACC_W+1){w_x[c_ACC_W]}};
        end else if (r_shift != '0) begin
            w_rnd = c_ONE << (r_shift - SHIFT_W'(1));
            w_sum = w_x + w_rnd;
            w_y   = w_sum >>> r_shift;
        end
    end

    assign w_sat_hi  = (w_y > c_PIX_MAX);
    assign w_sat_lo  = (w_y < c_PIX_MIN);
    assign w_pix     = w_sat_hi ? c_PIX_MAX[B_PIXEL-1:0] :
                       w_sat_lo ? c_PIX_MIN[B_PIXEL-1:0] : w_y[B_PIXEL-1:0];
    assign m_tdata_o = (r_state == S_SEND) ? w_pix : '0;

`ifdef ACC_DRAIN_STATS_EN
    logic [15:0] r_sat_cnt;
    logic        w_sat_evt;

    assign w_sat_evt = m_tvalid_o & m_tready_i & (w_sat_hi | w_sat_lo);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sat_cnt <= 16'd0;
        end else if (w_sat_evt && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt_o = r_sat_cnt;
`else
    assign sat_cnt_o = 16'd0;
`endif

endmodule
`default_nettype wire
